// File: rtl/gate_test_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// gate_test_sequencer_pkg
//   Gate encodings, sequencer state type and the golden truth-table function.
//   Revision: 1.0
// ============================================================================
package gate_test_sequencer_pkg;

   localparam logic [2:0] GATE_AND  = 3'd0;
   localparam logic [2:0] GATE_OR   = 3'd1;
   localparam logic [2:0] GATE_NAND = 3'd2;
   localparam logic [2:0] GATE_NOR  = 3'd3;
   localparam logic [2:0] GATE_XOR  = 3'd4;
   localparam logic [2:0] GATE_XNOR = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   function automatic logic sel_is_legal(input logic [2:0] sel);
      return (sel <= GATE_XNOR);
   endfunction

   // Illegal selects return 0; callers gate them out via sel_is_legal.
   function automatic logic expected_y(input logic [2:0] sel, input logic a, input logic b);
      logic y;
      case (sel)
         GATE_AND:  y = a & b;
         GATE_OR:   y = a | b;
         GATE_NAND: y = ~(a & b);
         GATE_NOR:  y = ~(a | b);
         GATE_XOR:  y = a ^ b;
         GATE_XNOR: y = ~(a ^ b);
         default:   y = 1'b0;
      endcase
      return y;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gate_test_sequencer_if.sv
`default_nettype none
// ============================================================================
// gate_test_sequencer_if
//   Control, gate-drive and result signals between the sequencer and its user.
//   Revision: 1.0
// ============================================================================
interface gate_test_sequencer_if;

   logic       start;
   logic [2:0] gate_sel;
   logic       A;
   logic       B;
   logic       Y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;
   logic       sel_err;

   // master: the sequencer itself; slave: the environment that starts it and hosts the gate
   modport master (
      input  start, gate_sel, Y,
      output A, B, busy, done, pass, err_count, fail_vec, sel_err
   );

   modport slave (
      output start, gate_sel, Y,
      input  A, B, busy, done, pass, err_count, fail_vec, sel_err
   );

endinterface
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// gate_ref_model
//   Combinational golden output for a 2-input gate of the selected type.
//   Revision: 1.0
// ============================================================================
module gate_ref_model
   import gate_test_sequencer_pkg::*;
(
   input  wire logic [2:0] sel_i,
   input  wire logic       a_i,
   input  wire logic       b_i,
   output logic            y_o
);

   assign y_o = expected_y(sel_i, a_i, b_i);

endmodule
`default_nettype wire

// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// gate_test_sequencer
//   Walks {A,B} through 00..11, holds each DWELL cycles, checks Y per gate type.
//   Revision: 1.0
// ============================================================================
module gate_test_sequencer
   import gate_test_sequencer_pkg::*;
#(
   parameter int DWELL = 2
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   gate_test_sequencer_if.master  bus
);

   localparam int                CNT_W    = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = (CNT_W)'(DWELL - 1);

   seq_state_e        state_q;
   logic [1:0]        vec_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        sel_q;
   logic              a_q;
   logic              b_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [2:0]        err_count_q;
   logic [3:0]        fail_vec_q;
   logic              sel_err_q;

   logic              y_exp;
   logic              mismatch;
   logic [2:0]        err_count_d;
   logic [3:0]        fail_vec_d;

   // a_q/b_q always equal vec_q while in CHECK, so they address the model directly
   gate_ref_model u_ref (
      .sel_i (sel_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .y_o   (y_exp)
   );

   always_comb begin
      mismatch    = (bus.Y != y_exp);
      err_count_d = err_count_q + {2'b00, mismatch};
      fail_vec_d  = fail_vec_q | (mismatch ? (4'b0001 << vec_q) : 4'b0000);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         vec_q       <= 2'd0;
         cnt_q       <= '0;
         sel_q       <= 3'd0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= 3'd0;
         fail_vec_q  <= 4'd0;
         sel_err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               a_q <= 1'b0;
               b_q <= 1'b0;
               if (bus.start) begin
                  sel_q       <= bus.gate_sel;
                  pass_q      <= 1'b0;
                  err_count_q <= 3'd0;
                  fail_vec_q  <= 4'd0;
                  busy_q      <= 1'b1;
                  vec_q       <= 2'd0;
                  cnt_q       <= '0;
                  if (sel_is_legal(bus.gate_sel)) begin
                     sel_err_q <= 1'b0;
                     state_q   <= ST_APPLY;
                  end else begin
                     sel_err_q <= 1'b1;
                     done_q    <= 1'b1;
                     state_q   <= ST_DONE;
                  end
               end
            end
            ST_APPLY: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               err_count_q <= err_count_d;
               fail_vec_q  <= fail_vec_d;
               if (vec_q == 2'd3) begin
                  // pass must include this final comparison, hence the _d values
                  pass_q  <= ~sel_err_q & (err_count_d == 3'd0);
                  done_q  <= 1'b1;
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  vec_q      <= vec_q + 2'd1;
                  {a_q, b_q} <= vec_q + 2'd1;
                  cnt_q      <= '0;
                  state_q    <= ST_APPLY;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_count_q;
   assign bus.fail_vec  = fail_vec_q;
   assign bus.sel_err   = sel_err_q;

endmodule
`default_nettype wire
